mem_ctrl: RTL and testbench
===========================

// Module: mem_ctrl
// PURPOSE
//  Single-port byte-wide RAM arbiter between the IF fetch path and the MEM stage.
//  MEM byte requests (mem_req/mem_r_w/addr/data) get absolute priority every cycle; IF gets 4-byte instruction fetches.
//  Read data returns to MEM one cycle after the request cycle, matching the MEM stage's byte sequencer.
//  IF fetches are assembled internally and delivered as one little-endian 32-bit word.
// PARAMETERS
//  RAM_ADDR_W  17  RAM address width; the low RAM_ADDR_W bits of every 32-bit address are driven out.
// PORTS
//  clk            in   1   clock, all state on rising edge
//  rst            in   1   asynchronous, active-high reset
//  mem_req        in   1   MEM stage byte request valid this cycle
//  mem_r_w        in   1   1 = write, 0 = read
//  mem_req_addr   in   32  MEM byte address
//  mem_req_data   in   8   MEM write byte
//  mem_data_o     out  8   read byte to MEM (memctrl_data_in); valid the cycle after the read request
//  if_req         in   1   IF wants the instruction at if_addr
//  if_addr        in   32  fetch address; byte n is at if_addr+n
//  if_flush       in   1   abort current fetch (branch/jump); no if_done for it
//  if_inst_o      out  32  fetched instruction {b3,b2,b1,b0}
//  if_done_o      out  1   one-cycle pulse: if_inst_o valid
//  ram_addr_o     out  RAM_ADDR_W  RAM byte address (combinational mux)
//  ram_wr_o       out  1   RAM write enable (combinational)
//  ram_dout_o     out  8   RAM write byte
//  ram_din_i      in   8   RAM read byte; 1-cycle latency from ram_addr_o
// BEHAVIOUR
//  Reset: if_inst_o=0, if_done_o=0, fetch FSM IDLE, byte counters 0, issue tracker empty.
//   While rst=1: ram_wr_o=0, ram_addr_o=0, ram_dout_o=0.
//  Port mux, per cycle:
//   - mem_req=1: ram_addr_o=mem_req_addr, ram_wr_o=mem_r_w, ram_dout_o=mem_req_data.
//   - else if the fetch FSM is issuing: ram_addr_o=if_addr+issue_idx, ram_wr_o=0.
//   - else: ram_wr_o=0, ram_addr_o holds 0.
//  mem_data_o = ram_din_i (pass-through); MEM samples it at the end of the cycle after its request.
//  Repeated writes of the same byte/address on consecutive mem_req cycles are legal and idempotent.
//  Fetch FSM:
//   - IDLE: if_req && !if_flush -> FETCH with issue_idx=0, recv_idx=0.
//   - FETCH: each cycle without mem_req and issue_idx<4 issues byte issue_idx and increments it.
//     A registered tag (valid, idx) records an IF issue; the next cycle captures ram_din_i into byte[idx] and increments recv_idx.
//     When recv_idx reaches 4 -> DONE.
//   - DONE: if_inst_o latched, if_done_o=1 for exactly one cycle, then IDLE.
//   - Latency with no contention: issue cycles 0..3, captures end of 1..4, if_done_o high in cycle 5.
//  MEM preemption:
//   - Any cycle with mem_req=1 cancels the in-flight fetch: the tag is cleared, so the following byte is not captured.
//   - issue_idx and recv_idx reset to 0; the fetch restarts from byte 0 in the first cycle with mem_req=0.
//   - No partial word is ever reported.
//  if_flush=1 in any state: clear tag, counters 0, suppress if_done_o, go IDLE.
//   - if_flush with if_req the same cycle: the new fetch starts the next cycle.
//  if_req dropping mid-fetch: treated as a flush.
//  if_addr must be stable while if_req=1; a change requires if_flush.
//  Address arithmetic: if_addr+issue_idx is 32-bit, truncated to RAM_ADDR_W; wraps at 2^RAM_ADDR_W.
//  Async reset mid-fetch or mid-MEM access: everything returns to reset values immediately. The MEM stage is reset with it.
// TESTING
//  1. RAM[0x100..0x103]=13,05,00,00, if_req@0x100 -> if_done pulse in cycle 5, if_inst_o=0x00000513, ram_wr_o never 1.
//  2. MEM read 0x200 (RAM=0xAB) with no IF activity -> ram_addr_o=0x200 in cycle c, mem_data_o=0xAB in c+1.
//  3. Fetch 0x100 with mem_req on cycles 2-5 -> fetch restarts at byte 0; if_done in cycle 11, word correct, MEM gets its bytes.
//  4. MEM SW 0x11223344 to 0x40 -> RAM[0x40..0x43]=44,33,22,11; a fetch from 0x40 then returns 0x11223344.
//  5. if_flush in cycle 3 of fetch 0x100 with new if_addr=0x200 -> no done for 0x100; done 6 cycles later with the word at 0x200.
//  6. Assert rst mid-fetch (cycle 2) -> if_done_o=0, ram_wr_o=0 immediately; after release, a fresh fetch completes in 5 cycles.

Source files
------------

// File: rtl/mem_ctrl_if.sv
// Bus bundle between the RAM arbiter and its IF/MEM clients and the byte RAM.
interface mem_ctrl_if #(parameter int RAM_ADDR_W = 17);
   logic                  mem_req;
   logic                  mem_r_w;
   logic [31:0]           mem_req_addr;
   logic [7:0]            mem_req_data;
   logic [7:0]            mem_data_o;
   logic                  if_req;
   logic [31:0]           if_addr;
   logic                  if_flush;
   logic [31:0]           if_inst_o;
   logic                  if_done_o;
   logic [RAM_ADDR_W-1:0] ram_addr_o;
   logic                  ram_wr_o;
   logic [7:0]            ram_dout_o;
   logic [7:0]            ram_din_i;

   // Arbiter side
   modport slave (
      input  mem_req, mem_r_w, mem_req_addr, mem_req_data,
      input  if_req, if_addr, if_flush, ram_din_i,
      output mem_data_o, if_inst_o, if_done_o, ram_addr_o, ram_wr_o, ram_dout_o
   );

   // Client / RAM side
   modport master (
      output mem_req, mem_r_w, mem_req_addr, mem_req_data,
      output if_req, if_addr, if_flush, ram_din_i,
      input  mem_data_o, if_inst_o, if_done_o, ram_addr_o, ram_wr_o, ram_dout_o
   );
endinterface

// File: rtl/mem_ctrl.sv
// Single-port byte RAM arbiter: MEM byte accesses always win, IF gets
// 4-byte instruction fetches assembled into a little-endian word.
module mem_ctrl #(
   parameter int RAM_ADDR_W = 17
) (
   input logic       clk,
   input logic       rst,
   mem_ctrl_if.slave bus
);

   typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

   state_t          state_q, state_d;
   logic [2:0]      issue_q, issue_d;
   logic [2:0]      recv_q, recv_d;
   logic            tag_vld_q, tag_vld_d;
   logic [1:0]      tag_idx_q, tag_idx_d;
   logic [3:0][7:0] byte_q, byte_d;
   logic [31:0]     inst_q, inst_d;
   logic            issuing;
   logic [31:0]     fetch_addr;
   logic            unused_hi;

   // Byte n of the fetch sits at if_addr+n; high bits drop off so the RAM wraps.
   assign fetch_addr = bus.if_addr + 32'(issue_q);
   assign unused_hi  = ^{fetch_addr[31:RAM_ADDR_W], bus.mem_req_addr[31:RAM_ADDR_W]};

   assign bus.mem_data_o = bus.ram_din_i;
   assign bus.if_inst_o  = inst_q;
   assign bus.if_done_o  = (state_q == DONE) && !bus.if_flush;

   // Fetch FSM: next state, byte issue/capture bookkeeping, word assembly.
   always_comb begin
      state_d   = state_q;
      issue_d   = issue_q;
      recv_d    = recv_q;
      tag_vld_d = 1'b0;
      tag_idx_d = tag_idx_q;
      byte_d    = byte_q;
      inst_d    = inst_q;
      issuing   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.if_req && !bus.if_flush) begin
               state_d = FETCH;
               issue_d = 3'd0;
               recv_d  = 3'd0;
               // Byte 0 goes out in the request cycle itself when MEM is quiet.
               if (!bus.mem_req) begin
                  issuing   = 1'b1;
                  tag_vld_d = 1'b1;
                  tag_idx_d = 2'd0;
                  issue_d   = 3'd1;
               end
            end
         end
         FETCH: begin
            if (bus.if_flush || !bus.if_req) begin
               state_d = IDLE;
               issue_d = 3'd0;
               recv_d  = 3'd0;
            end else if (bus.mem_req) begin
               // MEM steals the port: drop the outstanding byte and start over.
               issue_d = 3'd0;
               recv_d  = 3'd0;
            end else begin
               if (tag_vld_q) begin
                  byte_d[tag_idx_q] = bus.ram_din_i;
                  recv_d            = recv_q + 3'd1;
               end
               if (issue_q < 3'd4) begin
                  issuing   = 1'b1;
                  tag_vld_d = 1'b1;
                  tag_idx_d = issue_q[1:0];
                  issue_d   = issue_q + 3'd1;
               end
               if (recv_d == 3'd4) begin
                  state_d = DONE;
                  inst_d  = byte_d;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            issue_d = 3'd0;
            recv_d  = 3'd0;
         end
         default: state_d = IDLE;
      endcase
   end

   // Port mux: MEM first, then an IF issue, otherwise the port idles at 0.
   always_comb begin
      bus.ram_addr_o = '0;
      bus.ram_wr_o   = 1'b0;
      bus.ram_dout_o = 8'h00;
      if (!rst) begin
         if (bus.mem_req) begin
            bus.ram_addr_o = bus.mem_req_addr[RAM_ADDR_W-1:0];
            bus.ram_wr_o   = bus.mem_r_w;
            bus.ram_dout_o = bus.mem_req_data;
         end else if (issuing) begin
            bus.ram_addr_o = fetch_addr[RAM_ADDR_W-1:0];
         end
      end
   end

   // State registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         issue_q   <= 3'd0;
         recv_q    <= 3'd0;
         tag_vld_q <= 1'b0;
         tag_idx_q <= 2'd0;
         byte_q    <= '0;
         inst_q    <= 32'h0;
      end else begin
         state_q   <= state_d;
         issue_q   <= issue_d;
         recv_q    <= recv_d;
         tag_vld_q <= tag_vld_d;
         tag_idx_q <= tag_idx_d;
         byte_q    <= byte_d;
         inst_q    <= inst_d;
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte RAM model, shadow memory reference,
// directed scenarios plus randomized fetch/MEM contention.
module tb_mem_ctrl;
   localparam int AW = 17;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   mem_ctrl_if #(.RAM_ADDR_W(AW)) bus ();
   mem_ctrl #(.RAM_ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   // Unwritten bytes hold a fixed pattern of their address.
   function automatic logic [7:0] init_byte(input logic [AW-1:0] a);
      return 8'(a * 37 + (a >> 8) * 11 + 5);
   endfunction

   // RAM: 1-cycle read latency, write on clock edge.
   logic [7:0] ram     [0:(1<<AW)-1];
   logic       ram_wr  [0:(1<<AW)-1];
   logic [7:0] rdata;
   assign bus.ram_din_i = rdata;
   always @(posedge clk) begin
      rdata <= ram_wr[bus.ram_addr_o] ? ram[bus.ram_addr_o] : init_byte(bus.ram_addr_o);
      if (bus.ram_wr_o) begin
         ram[bus.ram_addr_o]    <= bus.ram_dout_o;
         ram_wr[bus.ram_addr_o] <= 1'b1;
      end
   end

   // Reference memory contents as seen by software.
   logic [7:0] sh [int];
   function automatic logic [7:0] sh_rd(input logic [31:0] a);
      int k;
      k = int'(a[AW-1:0]);
      return sh.exists(k) ? sh[k] : init_byte(a[AW-1:0]);
   endfunction
   function automatic logic [31:0] sh_word(input logic [31:0] a);
      return {sh_rd(a + 3), sh_rd(a + 2), sh_rd(a + 1), sh_rd(a)};
   endfunction

   // Fetch completes 5 cycles after the first 5-cycle window free of MEM traffic.
   function automatic int exp_done(input logic [31:0] m);
      for (int k = 0; k < 40; k++) begin
         automatic bit ok = 1'b1;
         for (int j = 0; j < 5; j++)
            if (k + j < 32 && m[k + j]) ok = 1'b0;
         if (ok) return k + 5;
      end
      return -1;
   endfunction

   task automatic idle_inputs();
      bus.mem_req = 0; bus.mem_r_w = 0; bus.mem_req_addr = 0; bus.mem_req_data = 0;
      bus.if_req = 0; bus.if_addr = 0; bus.if_flush = 0;
   endtask

   task automatic next_cycle();
      @(posedge clk); #1;
   endtask

   task automatic mem_write(input logic [31:0] a, input logic [7:0] d);
      bus.mem_req = 1; bus.mem_r_w = 1; bus.mem_req_addr = a; bus.mem_req_data = d;
      next_cycle();
      bus.mem_req = 0; bus.mem_r_w = 0;
      sh[int'(a[AW-1:0])] = d;
   endtask

   // Runs one fetch with MEM reads on the cycles set in mask; reports what it saw.
   task automatic do_fetch(input logic [31:0] addr, input logic [31:0] mask,
                           input logic [31:0] mbase, output int dcyc,
                           output logic [31:0] word, output int dcnt, output int bad);
      logic        pend;
      logic [31:0] paddr;
      dcyc = -1; word = 0; dcnt = 0; bad = 0; pend = 0; paddr = 0;
      for (int c = 0; c < 40 && dcyc < 0; c++) begin
         bus.if_req = 1; bus.if_addr = addr; bus.if_flush = 0;
         bus.mem_req = (c < 32) ? mask[c] : 1'b0;
         bus.mem_r_w = 0; bus.mem_req_addr = mbase + 32'(c);
         @(negedge clk);
         if (pend && bus.mem_data_o !== sh_rd(paddr)) bad++;
         if (bus.ram_wr_o) bad++;
         if (bus.mem_req && bus.ram_addr_o !== bus.mem_req_addr[AW-1:0]) bad++;
         pend = bus.mem_req; paddr = bus.mem_req_addr;
         if (bus.if_done_o) begin dcnt++; dcyc = c; word = bus.if_inst_o; end
         next_cycle();
      end
      bus.if_req = 0; bus.mem_req = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (pend && bus.mem_data_o !== sh_rd(paddr)) bad++;
         pend = 0;
         if (bus.if_done_o) dcnt++;
         next_cycle();
      end
   endtask

   task automatic test_reset();
      bus.mem_req = 1; bus.mem_r_w = 1; bus.mem_req_addr = 32'h123; bus.mem_req_data = 8'h5A;
      bus.if_req = 1; bus.if_addr = 32'h100;
      @(negedge clk);
      checks++; if (bus.ram_wr_o !== 1'b0) begin errors++; $display("FAIL reset_wr got %b exp 0", bus.ram_wr_o); end
      checks++; if (bus.ram_addr_o !== '0) begin errors++; $display("FAIL reset_addr got %h exp 0", bus.ram_addr_o); end
      checks++; if (bus.ram_dout_o !== 8'h00) begin errors++; $display("FAIL reset_dout got %h exp 0", bus.ram_dout_o); end
      checks++; if (bus.if_done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.if_done_o); end
      checks++; if (bus.if_inst_o !== 32'h0) begin errors++; $display("FAIL reset_inst got %h exp 0", bus.if_inst_o); end
      next_cycle();
      idle_inputs();
      rst = 0;
      next_cycle();
   endtask

   task automatic test_fetch();
      int d, n, b; logic [31:0] w;
      mem_write(32'h100, 8'h13); mem_write(32'h101, 8'h05);
      mem_write(32'h102, 8'h00); mem_write(32'h103, 8'h00);
      next_cycle();
      do_fetch(32'h100, 32'h0, 32'h0, d, w, n, b);
      checks++; if (d !== 5) begin errors++; $display("FAIL fetch_cycle got %0d exp 5", d); end
      checks++; if (w !== 32'h00000513) begin errors++; $display("FAIL fetch_word got %h exp 00000513", w); end
      checks++; if (n !== 1) begin errors++; $display("FAIL fetch_done_cnt got %0d exp 1", n); end
      checks++; if (b !== 0) begin errors++; $display("FAIL fetch_bus got %0d bad exp 0", b); end
   endtask

   task automatic test_mem_read();
      mem_write(32'h200, 8'hAB);
      bus.mem_req = 1; bus.mem_r_w = 0; bus.mem_req_addr = 32'h200;
      @(negedge clk);
      checks++; if (bus.ram_addr_o !== 17'h200) begin errors++; $display("FAIL rd_addr got %h exp 200", bus.ram_addr_o); end
      checks++; if (bus.ram_wr_o !== 1'b0) begin errors++; $display("FAIL rd_wr got %b exp 0", bus.ram_wr_o); end
      next_cycle();
      bus.mem_req = 0;
      @(negedge clk);
      checks++; if (bus.mem_data_o !== 8'hAB) begin errors++; $display("FAIL rd_data got %h exp AB", bus.mem_data_o); end
      next_cycle();
   endtask

   task automatic test_preempt();
      int d, n, b; logic [31:0] w;
      do_fetch(32'h100, 32'h3C, 32'h300, d, w, n, b);
      checks++; if (d !== 11) begin errors++; $display("FAIL preempt_cycle got %0d exp 11", d); end
      checks++; if (w !== sh_word(32'h100)) begin errors++; $display("FAIL preempt_word got %h exp %h", w, sh_word(32'h100)); end
      checks++; if (n !== 1) begin errors++; $display("FAIL preempt_done_cnt got %0d exp 1", n); end
      checks++; if (b !== 0) begin errors++; $display("FAIL preempt_mem got %0d bad exp 0", b); end
   endtask

   task automatic test_mem_write();
      int d, n, b; logic [31:0] w;
      logic [31:0] sw;
      logic [7:0]  seq_d [5];
      logic [31:0] seq_a [5];
      sw = 32'h11223344;
      // Byte 0 is written twice back to back; the repeat must be harmless.
      seq_a = '{32'h40, 32'h40, 32'h41, 32'h42, 32'h43};
      seq_d = '{sw[7:0], sw[7:0], sw[15:8], sw[23:16], sw[31:24]};
      for (int i = 0; i < 5; i++) begin
         bus.mem_req = 1; bus.mem_r_w = 1; bus.mem_req_addr = seq_a[i]; bus.mem_req_data = seq_d[i];
         @(negedge clk);
         checks++;
         if (bus.ram_wr_o !== 1'b1 || bus.ram_dout_o !== seq_d[i] || bus.ram_addr_o !== seq_a[i][AW-1:0]) begin
            errors++; $display("FAIL wr_port%0d got wr=%b d=%h a=%h exp wr=1 d=%h a=%h",
                               i, bus.ram_wr_o, bus.ram_dout_o, bus.ram_addr_o, seq_d[i], seq_a[i][AW-1:0]);
         end
         sh[int'(seq_a[i][AW-1:0])] = seq_d[i];
         next_cycle();
      end
      idle_inputs();
      next_cycle();
      do_fetch(32'h40, 32'h0, 32'h0, d, w, n, b);
      checks++; if (w !== 32'h11223344) begin errors++; $display("FAIL sw_fetch_word got %h exp 11223344", w); end
      checks++; if (d !== 5) begin errors++; $display("FAIL sw_fetch_cycle got %0d exp 5", d); end
   endtask

   task automatic test_flush();
      int first, n; logic [31:0] w;
      first = -1; n = 0; w = 0;
      for (int c = 0; c < 16; c++) begin
         bus.if_req   = (first < 0);
         bus.if_addr  = (c < 3) ? 32'h100 : 32'h200;
         bus.if_flush = (c == 3);
         @(negedge clk);
         if (bus.if_done_o) begin n++; if (first < 0) begin first = c; w = bus.if_inst_o; end end
         next_cycle();
      end
      idle_inputs();
      checks++; if (first !== 9) begin errors++; $display("FAIL flush_cycle got %0d exp 9", first); end
      checks++; if (w !== sh_word(32'h200)) begin errors++; $display("FAIL flush_word got %h exp %h", w, sh_word(32'h200)); end
      checks++; if (n !== 1) begin errors++; $display("FAIL flush_done_cnt got %0d exp 1", n); end
   endtask

   task automatic test_reset_mid();
      int d, n, b; logic [31:0] w;
      bus.if_req = 1; bus.if_addr = 32'h100;
      next_cycle(); next_cycle();
      // Cycle 2 of the fetch: reset hits while MEM also drives a write.
      bus.mem_req = 1; bus.mem_r_w = 1; bus.mem_req_addr = 32'h77; bus.mem_req_data = 8'hEE;
      rst = 1;
      @(negedge clk);
      checks++; if (bus.if_done_o !== 1'b0 || bus.ram_wr_o !== 1'b0 || bus.ram_addr_o !== '0) begin
         errors++; $display("FAIL midrst_outs got done=%b wr=%b a=%h exp 0 0 0", bus.if_done_o, bus.ram_wr_o, bus.ram_addr_o);
      end
      next_cycle();
      idle_inputs();
      rst = 0;
      next_cycle();
      do_fetch(32'h100, 32'h0, 32'h0, d, w, n, b);
      checks++; if (d !== 5 || w !== 32'h00000513) begin
         errors++; $display("FAIL midrst_refetch got cyc=%0d w=%h exp cyc=5 w=00000513", d, w);
      end
   endtask

   task automatic test_wrap();
      int d, n, b; logic [31:0] w, a;
      a = 32'hABC1FFFE;
      do_fetch(a, 32'h0, 32'h0, d, w, n, b);
      checks++; if (w !== {sh_rd(32'h1), sh_rd(32'h0), sh_rd(32'h1FFFF), sh_rd(32'h1FFFE)}) begin
         errors++; $display("FAIL wrap_word got %h exp %h", w, {sh_rd(32'h1), sh_rd(32'h0), sh_rd(32'h1FFFF), sh_rd(32'h1FFFE)});
      end
   endtask

   task automatic test_random();
      int d, n, b, e; logic [31:0] w, a, m, mb;
      for (int it = 0; it < 24; it++) begin
         a  = $urandom;
         m  = ($urandom & $urandom) & 32'h0000FFFF;
         mb = $urandom;
         e  = exp_done(m);
         do_fetch(a, m, mb, d, w, n, b);
         checks++;
         if (d !== e || w !== sh_word(a) || n !== 1 || b !== 0) begin
            errors++;
            $display("FAIL rand%0d got cyc=%0d w=%h dn=%0d bad=%0d exp cyc=%0d w=%h dn=1 bad=0",
                     it, d, w, n, b, e, sh_word(a));
         end
      end
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) ram_wr[i] = 1'b0;
      rst = 1;
      idle_inputs();
      next_cycle();
      test_reset();
      test_fetch();
      test_mem_read();
      test_preempt();
      test_mem_write();
      test_flush();
      test_reset_mid();
      test_wrap();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
